// File: rtl/logphy_pkg.sv
// Constants and types shared by the logphy Queue, the lane striper and the de-striper.
package logphy_pkg;
    localparam int FLIT_W = 128;
    localparam int BYTE_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } striper_state_t;
endpackage

// File: rtl/lane_striper.sv
// Byte-stripes 128-bit flits from the Queue across LANES byte lanes, one
// LANES-byte beat per handshake, with no bubble between back-to-back flits.
module lane_striper
    import logphy_pkg::*;
#(
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      deq_valid_i,
    output logic                      deq_rdy_o,
    input  logic [FLIT_W-1:0]         data_i,
    output logic                      lane_valid_o,
    input  logic                      lane_rdy_i,
    output logic [LANES*BYTE_W-1:0]   lane_data_o,
    output logic                      flit_start_o,
    output logic                      flit_end_o,
    output logic [CNT_W-1:0]          flit_cnt_o
);
    localparam int LANE_W = LANES * BYTE_W;
    localparam int BEATS  = FLIT_W / LANE_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    striper_state_t                  state_q, state_d;
    logic [BEATS-1:0][LANE_W-1:0]    flit_q;
    logic [BEAT_W-1:0]               beat_q;
    logic [CNT_W-1:0]                cnt_q;
    logic                            sending, last_beat, beat_done, accept;

    assign sending   = (state_q == SEND);
    assign last_beat = sending && (beat_q == LAST_BEAT);
    assign beat_done = sending && lane_rdy_i;
    assign accept    = deq_valid_i && deq_rdy_o;

    // Lane outputs come only from flit_q, so data_i never reaches the lanes combinationally.
    assign lane_valid_o = sending;
    assign lane_data_o  = sending ? flit_q[beat_q] : '0;
    assign flit_start_o = sending && (beat_q == '0);
    assign flit_end_o   = last_beat;
    assign deq_rdy_o    = !sending || (last_beat && lane_rdy_i);
    assign flit_cnt_o   = cnt_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (deq_valid_i) state_d = SEND;
            SEND:    if (lane_rdy_i && last_beat && !deq_valid_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flit_q <= '0;
            beat_q <= '0;
            cnt_q  <= '0;
        end else begin
            // A new flit lands on the same edge the previous last beat leaves.
            if (accept) begin
                flit_q <= data_i;
                beat_q <= '0;
            end else if (beat_done && !last_beat) begin
                beat_q <= beat_q + 1'b1;
            end
            if (beat_done && last_beat) cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_lane_striper.sv
// Scoreboard bench: stimulus queues expected beats, negedge monitors pop and compare.
module tb_lane_striper;
    import logphy_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          dv4 = 0, dr4, lv4, lr4 = 0, fs4, fe4;
    logic [127:0]  din4 = '0;
    logic [31:0]   ld4;
    logic [3:0]    fc4;
    logic          dv16 = 0, dr16, lv16, lr16 = 0, fs16, fe16;
    logic [127:0]  din16 = '0, ld16;
    logic [15:0]   fc16;

    lane_striper #(.LANES(4), .CNT_W(4)) u4 (
        .clk(clk), .reset(reset), .deq_valid_i(dv4), .deq_rdy_o(dr4), .data_i(din4),
        .lane_valid_o(lv4), .lane_rdy_i(lr4), .lane_data_o(ld4),
        .flit_start_o(fs4), .flit_end_o(fe4), .flit_cnt_o(fc4));

    lane_striper #(.LANES(16), .CNT_W(16)) u16 (
        .clk(clk), .reset(reset), .deq_valid_i(dv16), .deq_rdy_o(dr16), .data_i(din16),
        .lane_valid_o(lv16), .lane_rdy_i(lr16), .lane_data_o(ld16),
        .flit_start_o(fs16), .flit_end_o(fe16), .flit_cnt_o(fc16));

    typedef struct {
        logic [127:0] d;
        logic         s;
        logic         e;
    } beat_t;

    beat_t q4[$];
    beat_t q16[$];
    beat_t m4, m16;
    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [127:0] FA = 128'hAABBCCDDEEFF00112233445566778899;
    localparam logic [127:0] FR = 128'h0F0E0D0C0B0A09080706050403020100;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic exp4h(input logic [31:0] b0, input logic [31:0] b1,
                         input logic [31:0] b2, input logic [31:0] b3);
        beat_t t;
        t.d = 128'(b0); t.s = 1'b1; t.e = 1'b0; q4.push_back(t);
        t.d = 128'(b1); t.s = 1'b0; q4.push_back(t);
        t.d = 128'(b2); q4.push_back(t);
        t.d = 128'(b3); t.e = 1'b1; q4.push_back(t);
    endtask

    task automatic exp4(input logic [127:0] d);
        exp4h(d[31:0], d[63:32], d[95:64], d[127:96]);
    endtask

    task automatic acc4(input logic [127:0] d);
        int n;
        n = 0;
        dv4 = 1'b1; din4 = d;
        do begin @(negedge clk); n++; end while (!dr4 && n < 40);
        chk("u4_deq_handshake", 128'(dr4), 128'd1);
        @(posedge clk); #1;
        dv4 = 1'b0; din4 = '0;
    endtask

    task automatic acc16(input logic [127:0] d);
        int n;
        n = 0;
        dv16 = 1'b1; din16 = d;
        do begin @(negedge clk); n++; end while (!dr16 && n < 40);
        chk("u16_deq_handshake", 128'(dr16), 128'd1);
        @(posedge clk); #1;
        dv16 = 1'b0; din16 = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q4.size() != 0 || q16.size() != 0) && n < 200) begin
            @(negedge clk); n++;
        end
        chk("drain_timeout", 128'(q4.size() + q16.size()), 128'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; dv4 = 0; dv16 = 0;
        q4.delete(); q16.delete();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (lv4 && lr4) begin
            if (q4.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL u4_extra_beat: got %h expected no beat", ld4);
            end else begin
                m4 = q4.pop_front();
                chk("u4_data",  128'(ld4), m4.d);
                chk("u4_start", 128'(fs4), 128'(m4.s));
                chk("u4_end",   128'(fe4), 128'(m4.e));
            end
        end
        if (lv16 && lr16) begin
            if (q16.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL u16_extra_beat: got %h expected no beat", ld16);
            end else begin
                m16 = q16.pop_front();
                chk("u16_data",  ld16, m16.d);
                chk("u16_start", 128'(fs16), 128'(m16.s));
                chk("u16_end",   128'(fe16), 128'(m16.e));
            end
        end
    end

    logic [9:0]   vpat, rpat;
    logic [6:0]   vpat16, sepat16;
    logic [127:0] f16 [5];
    logic [127:0] fw;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 128'(lv4), 128'd0);
        chk("rst_data",  128'(ld4), 128'd0);
        chk("rst_start_end", 128'({fs4, fe4}), 128'd0);
        chk("rst_cnt",   128'(fc4), 128'd0);
        reset = 1'b0;
        #1;
        chk("rst_deq_rdy4",  128'(dr4),  128'd1);
        chk("rst_deq_rdy16", 128'(dr16), 128'd1);

        // Single flit, downstream always ready
        lr4 = 1'b1;
        exp4h(32'h66778899, 32'h22334455, 32'hEEFF0011, 32'hAABBCCDD);
        acc4(FA);
        drain();
        chk("t1_cnt", 128'(fc4), 128'd1);

        // Stall for 3 cycles on beat 1
        do_reset();
        lr4 = 1'b1;
        exp4h(32'h66778899, 32'h22334455, 32'hEEFF0011, 32'hAABBCCDD);
        acc4(FA);
        @(posedge clk); #1;
        lr4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_hold_data",  128'(ld4), 128'h22334455);
            chk("t2_hold_valid", 128'(lv4), 128'd1);
            chk("t2_hold_rdy",   128'(dr4), 128'd0);
            @(posedge clk); #1;
        end
        lr4 = 1'b1;
        drain();
        chk("t2_cnt", 128'(fc4), 128'd1);

        // Two back-to-back flits: 8 beats with no gap
        do_reset();
        lr4 = 1'b1;
        exp4(128'h00112233445566778899AABBCCDDEEFF);
        exp4(128'hFEDCBA98765432100F1E2D3C4B5A6978);
        fork
            begin
                acc4(128'h00112233445566778899AABBCCDDEEFF);
                acc4(128'hFEDCBA98765432100F1E2D3C4B5A6978);
            end
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    vpat[i] = lv4;
                    rpat[i] = dr4;
                end
            end
        join
        chk("t3_valid_pattern", 128'(vpat), 128'(10'b0111111110));
        chk("t3_rdy_pattern",   128'(rpat), 128'(10'b1100010001));
        drain();
        chk("t3_cnt", 128'(fc4), 128'd2);

        // LANES=16: one flit per cycle
        do_reset();
        lr16 = 1'b1;
        f16[0] = 128'h0123456789ABCDEF0011223344556677;
        f16[1] = 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF;
        f16[2] = 128'h00000000000000000000000000000001;
        f16[3] = 128'h80000000000000000000000000000000;
        f16[4] = 128'hDEADBEEFCAFEF00D5A5A5A5AA5A5A5A5;
        for (int k = 0; k < 5; k++) begin
            m16.d = f16[k]; m16.s = 1'b1; m16.e = 1'b1;
            q16.push_back(m16);
        end
        fork
            for (int k = 0; k < 5; k++) acc16(f16[k]);
            begin
                for (int i = 0; i < 7; i++) begin
                    @(negedge clk);
                    vpat16[i]  = lv16;
                    sepat16[i] = fs16 & fe16;
                end
            end
        join
        chk("t4_valid_pattern", 128'(vpat16),  128'(7'b0111110));
        chk("t4_se_pattern",    128'(sepat16), 128'(7'b0111110));
        drain();
        chk("t4_cnt", 128'(fc16), 128'd5);

        // Reset during beat 2, then a clean flit
        do_reset();
        lr4 = 1'b1;
        exp4h(32'h66778899, 32'h22334455, 32'hEEFF0011, 32'hAABBCCDD);
        acc4(FA);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t5_beat2_data", 128'(ld4), 128'hEEFF0011);
        reset = 1'b1;
        #1;
        chk("t5_rst_valid", 128'(lv4), 128'd0);
        chk("t5_rst_data",  128'(ld4), 128'd0);
        chk("t5_rst_se",    128'({fs4, fe4}), 128'd0);
        chk("t5_rst_cnt",   128'(fc4), 128'd0);
        q4.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("t5_rdy_after", 128'(dr4), 128'd1);
        exp4h(32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C);
        acc4(FR);
        drain();
        chk("t5_cnt", 128'(fc4), 128'd1);

        // 17 flits into a 4-bit counter wrap to 1
        do_reset();
        lr4 = 1'b1;
        for (int k = 0; k < 17; k++) begin
            fw = {4{32'(k) * 32'h01010101}};
            exp4(fw);
        end
        for (int k = 0; k < 17; k++) begin
            fw = {4{32'(k) * 32'h01010101}};
            acc4(fw);
        end
        drain();
        chk("t6_cnt_wrap", 128'(fc4), 128'd1);

        chk("final_q_empty", 128'(q4.size() + q16.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
